// File: rtl/procyon_ieu_wb.sv
// IEU writeback queue: buffers execute results in order until the CDB
// arbiter grants this unit, with back-pressure that covers one in-flight op.
module procyon_ieu_wb #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_IEU_WB_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_data,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_addr,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_tag,
  input  logic                          i_redirect,
  input  logic                          i_valid,
  input  logic                          i_cdb_gnt,
  output logic                          o_cdb_req,
  output logic [OPTN_DATA_WIDTH-1:0]    o_cdb_data,
  output logic [OPTN_ADDR_WIDTH-1:0]    o_cdb_addr,
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_cdb_tag,
  output logic                          o_cdb_redirect,
  output logic                          o_stall,
  output logic [$clog2(OPTN_IEU_WB_DEPTH):0] o_count
);

  localparam int DEPTH = OPTN_IEU_WB_DEPTH;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  typedef struct packed {
    logic [OPTN_DATA_WIDTH-1:0]    data;
    logic [OPTN_ADDR_WIDTH-1:0]    addr;
    logic [OPTN_ROB_IDX_WIDTH-1:0] tag;
    logic                          redirect;
  } wb_entry_t;

  wb_entry_t       mem [DEPTH];
  wb_entry_t       head;
  wb_entry_t       in_entry;
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   wptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   space;
  logic            full;
  logic            pop;
  logic            push;
  logic            push_ok;

  assign full     = (count == CW'(DEPTH));
  assign space    = CW'(DEPTH) - count;
  assign pop      = o_cdb_req & i_cdb_gnt & ~i_flush;
  assign push     = i_valid & ~i_flush;
  // a push into a full queue is only accepted if the head leaves this edge
  assign push_ok  = push & (~full | pop);

  assign in_entry.data     = i_data;
  assign in_entry.addr     = i_addr;
  assign in_entry.tag      = i_tag;
  assign in_entry.redirect = i_redirect;

  assign head           = mem[rptr];
  assign o_cdb_req      = (count != '0);
  assign o_cdb_data     = head.data;
  assign o_cdb_addr     = head.addr;
  assign o_cdb_tag      = head.tag;
  assign o_cdb_redirect = head.redirect;
  assign o_stall        = (space <= CW'(1));
  assign o_count        = count;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else if (i_flush) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: tb/tb_procyon_ieu_wb.sv
// Directed and scoreboarded checks for the IEU writeback queue.
module tb_procyon_ieu_wb;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_flush;
  logic [31:0] i_data;
  logic [31:0] i_addr;
  logic [4:0]  i_tag;
  logic        i_redirect;
  logic        i_valid;
  logic        i_cdb_gnt;
  logic        o_cdb_req;
  logic [31:0] o_cdb_data;
  logic [31:0] o_cdb_addr;
  logic [4:0]  o_cdb_tag;
  logic        o_cdb_redirect;
  logic        o_stall;
  logic [2:0]  o_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } sb_t;
  sb_t sb [$];

  procyon_ieu_wb #(
    .OPTN_DATA_WIDTH(32),
    .OPTN_ADDR_WIDTH(32),
    .OPTN_ROB_IDX_WIDTH(5),
    .OPTN_IEU_WB_DEPTH(4)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .i_flush(i_flush),
    .i_data(i_data),
    .i_addr(i_addr),
    .i_tag(i_tag),
    .i_redirect(i_redirect),
    .i_valid(i_valid),
    .i_cdb_gnt(i_cdb_gnt),
    .o_cdb_req(o_cdb_req),
    .o_cdb_data(o_cdb_data),
    .o_cdb_addr(o_cdb_addr),
    .o_cdb_tag(o_cdb_tag),
    .o_cdb_redirect(o_cdb_redirect),
    .o_stall(o_stall),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] t,
                       input logic [31:0] d, input logic [31:0] a,
                       input logic r, input logic g);
    i_valid    = v;
    i_tag      = t;
    i_data     = d;
    i_addr     = a;
    i_redirect = r;
    i_cdb_gnt  = g;
  endtask

  initial begin
    n_rst   = 1'b0;
    i_flush = 1'b0;
    drive(1'b1, 5'd9, 32'h5, 32'h6, 1'b0, 1'b1);
    step();
    step();
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_req", 64'(o_cdb_req), 64'd0);
    check("rst_stall", 64'(o_stall), 64'd0);
    n_rst = 1'b1;

    // single push, granted immediately
    drive(1'b1, 5'd3, 32'h11, 32'h100, 1'b0, 1'b1);
    step();
    check("p1_req", 64'(o_cdb_req), 64'd1);
    check("p1_data", 64'(o_cdb_data), 64'h11);
    check("p1_addr", 64'(o_cdb_addr), 64'h100);
    check("p1_tag", 64'(o_cdb_tag), 64'd3);
    check("p1_redir", 64'(o_cdb_redirect), 64'd0);
    check("p1_count", 64'(o_count), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    check("p1_req_after", 64'(o_cdb_req), 64'd0);

    // fill three without grant, then drain in order
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'(i), 32'(i * 16), 32'h200, 1'b0, 1'b0);
      step();
      check("fill_count", 64'(o_count), 64'(i));
      check("fill_stall", 64'(o_stall), (i == 3) ? 64'd1 : 64'd0);
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check("hold_tag", 64'(o_cdb_tag), 64'd1);
    i_cdb_gnt = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check("drain_tag", 64'(o_cdb_tag), 64'(i));
      check("drain_data", 64'(o_cdb_data), 64'(i * 16));
      step();
    end
    check("drain_req", 64'(o_cdb_req), 64'd0);
    check("drain_stall", 64'(o_stall), 64'd0);

    // streaming push+pop, pointers wrap
    drive(1'b1, 5'd10, 32'ha0, 32'h0, 1'b0, 1'b1);
    step();
    for (int i = 11; i < 20; i++) begin
      check("strm_head", 64'(o_cdb_tag), 64'(i - 1));
      drive(1'b1, 5'(i), 32'(i * 16), 32'h0, 1'b0, 1'b1);
      step();
      check("strm_count", 64'(o_count), 64'd1);
    end
    check("strm_last", 64'(o_cdb_tag), 64'd19);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    check("strm_empty", 64'(o_cdb_req), 64'd0);

    // flush overrides push and pop
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'(20 + i), 32'h0, 32'h0, 1'b0, 1'b0);
      step();
    end
    check("pre_flush", 64'(o_count), 64'd3);
    drive(1'b1, 5'd30, 32'h0, 32'h0, 1'b0, 1'b1);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("fl_count", 64'(o_count), 64'd0);
    check("fl_req", 64'(o_cdb_req), 64'd0);
    check("fl_stall", 64'(o_stall), 64'd0);

    // reset mid-operation
    drive(1'b1, 5'd5, 32'h55, 32'h500, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd6, 32'h66, 32'h600, 1'b0, 1'b0);
    step();
    check("rr_count", 64'(o_count), 64'd2);
    check("rr_redir", 64'(o_cdb_redirect), 64'd1);
    check("rr_addr", 64'(o_cdb_addr), 64'h500);
    drive(1'b1, 5'd8, 32'h0, 32'h0, 1'b0, 1'b1);
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    check("rr_cnt0", 64'(o_count), 64'd0);
    check("rr_req0", 64'(o_cdb_req), 64'd0);
    drive(1'b1, 5'd7, 32'h77, 32'h700, 1'b0, 1'b0);
    step();
    check("rr_t7", 64'(o_cdb_tag), 64'd7);
    check("rr_t7cnt", 64'(o_count), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    check("rr_t7pop", 64'(o_cdb_req), 64'd0);

    // random traffic against a scoreboard
    sb.delete();
    for (int c = 0; c < 400; c++) begin
      logic v, g, f;
      logic [4:0] t;
      logic [31:0] d;
      f = ($urandom_range(0, 29) == 0);
      g = $urandom_range(0, 1);
      v = !o_stall && ($urandom_range(0, 3) != 0);
      t = 5'(c);
      d = $urandom;
      drive(v, t, d, 32'(c), 1'b0, g);
      i_flush = f;
      check("rnd_req", 64'(o_cdb_req), (sb.size() != 0) ? 64'd1 : 64'd0);
      if (f) begin
        sb.delete();
      end else begin
        if (g && sb.size() != 0) begin
          check("rnd_tag", 64'(o_cdb_tag), 64'(sb[0].tag));
          check("rnd_data", 64'(o_cdb_data), 64'(sb[0].data));
          void'(sb.pop_front());
        end
        if (v) sb.push_back('{data: d, tag: t});
      end
      step();
      check("rnd_count", 64'(o_count), 64'(sb.size()));
    end
    i_flush = 1'b0;
    i_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/procyon_ieu_wb.md
PROCYON_IEU_WB -- requirements
Module: procyon_ieu_wb

Interface
REQ-001 SHALL have parameter OPTN_DATA_WIDTH, default 32, result data width.
REQ-002 SHALL have parameter OPTN_ADDR_WIDTH, default 32, redirect/target address width.
REQ-003 SHALL have parameter OPTN_ROB_IDX_WIDTH, default 5, ROB tag width.
REQ-004 SHALL have parameter OPTN_IEU_WB_DEPTH, default 4, result queue entries; power of two, >=2.
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port n_rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port i_flush  input  1  pipeline flush.
REQ-008 SHALL have port i_data  input  OPTN_DATA_WIDTH  execute-stage result.
REQ-009 SHALL have port i_addr  input  OPTN_ADDR_WIDTH  execute-stage branch/jump target.
REQ-010 SHALL have port i_tag  input  OPTN_ROB_IDX_WIDTH  ROB tag of result.
REQ-011 SHALL have port i_redirect  input  1  execute-stage redirect flag.
REQ-012 SHALL have port i_valid  input  1  execute-stage result valid.
REQ-013 SHALL have port i_cdb_gnt  input  1  CDB arbiter grant for this unit.
REQ-014 SHALL have port o_cdb_req  output  1  CDB request; queue non-empty.
REQ-015 SHALL have ports o_cdb_data/o_cdb_addr/o_cdb_tag/o_cdb_redirect  output  widths as inputs  queue head fields.
REQ-016 SHALL have port o_stall  output  1  back-pressure to IEU issue.
REQ-017 SHALL have port o_count  output  $clog2(DEPTH)+1  current occupancy (debug/perf).

Function
REQ-018 SHALL store {data, addr, tag, redirect} per entry in a circular FIFO with registered read pointer, write pointer, and count.
REQ-019 SHALL push the input entry at the tail on a clock edge where i_valid=1 and i_flush=0.
REQ-020 SHALL pop the head on a clock edge where o_cdb_req=1 and i_cdb_gnt=1 and i_flush=0; i_cdb_gnt with o_cdb_req=0 SHALL be ignored.
REQ-021 SHALL keep count unchanged on simultaneous push and pop; both pointers advance.
REQ-022 SHALL wrap pointers modulo OPTN_IEU_WB_DEPTH.
REQ-023 SHALL drive o_cdb_req = (count != 0), combinationally from registered count.
REQ-024 SHALL drive o_cdb_* from the entry at the read pointer; values undefined when o_cdb_req=0.
REQ-025 SHALL have latency exactly 1 cycle: result pushed at edge N appears with o_cdb_req=1 after edge N if queue was empty.
REQ-026 SHALL deliver results to CDB in arrival order; no reordering, no drops.
REQ-027 SHALL drive o_stall = ((DEPTH - count) <= 1), combinationally from registered count, covering the one result already in flight through execute.
REQ-028 SHALL treat push while count==DEPTH and no pop as illegal; simulation assertion SHALL fire; entry state unchanged.
REQ-029 SHALL hold head stable while o_cdb_req=1 and i_cdb_gnt=0.
REQ-030 SHALL, on an edge with i_flush=1, clear count and both pointers, discarding queued entries and any same-cycle input; flush overrides push and pop.
REQ-031 SHALL show o_cdb_req=0 and o_stall=0 in the cycle after a flush edge.
REQ-032 SHALL not reset or clear entry data storage; only control state.

Reset
REQ-033 SHALL, on an edge with n_rst=0, clear count, read and write pointers to 0, regardless of i_valid, i_cdb_gnt, i_flush.
REQ-034 SHALL give after reset: o_cdb_req=0, o_stall=0, o_count=0.
REQ-035 SHALL give reset priority over flush, push and pop; reset mid-operation discards all entries.

Verification (DEPTH=4)
REQ-036 SHALL cover: push {data=0x11, addr=0x100, tag=3, redirect=0} into empty queue, gnt=1 -> o_cdb_req=1 next cycle with those fields, popped, o_cdb_req=0 following cycle.
REQ-037 SHALL cover: gnt=0, push tags 1,2,3 on consecutive cycles -> o_count=3, o_stall=1 after third push (o_stall=1 already at count=3); then gnt=1 -> tags pop in order 1,2,3.
REQ-038 SHALL cover: push every cycle with gnt every cycle for 10 cycles -> o_count stays 1, tags emerge in order, pointers wrap past 3 without loss.
REQ-039 SHALL cover: count=3, i_flush=1 with i_valid=1 and i_cdb_gnt=1 same cycle -> next cycle o_count=0, o_cdb_req=0, o_stall=0; nothing granted.
REQ-040 SHALL cover: count=2 with redirect entry at head, n_rst=0 one cycle -> o_count=0, o_cdb_req=0; subsequent push of tag 7 appears at head alone.
REQ-041 SHALL cover: random push/gnt/flush with issue obeying o_stall -> overflow assertion never fires; output order matches scoreboard.
